// File: rtl/mem_multicycle_resp_pkg.sv
// rtl/mem_multicycle_resp_pkg.sv - shared state encodings and constants for the multi-cycle memory responder
package mem_multicycle_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 4;

  // Wide enough for the largest legal latency (15)
  localparam int CNT_W = 4;

  localparam logic RESP_WR = 1'b1;
  localparam logic RESP_RD = 1'b0;

endpackage

// File: rtl/mem_array_1rw.sv
// rtl/mem_array_1rw.sv - single-port word array, synchronous write, asynchronous read, no reset
module mem_array_1rw #(
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 1024,
  localparam int IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_multicycle_resp.sv
// rtl/mem_multicycle_resp.sv - fixed-latency memory target: one request at a time, one-cycle response pulse
module mem_multicycle_resp
  import mem_multicycle_resp_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam state_t ACCEPT_STATE = (LATENCY == 1) ? RESP : WAIT;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              accept;
  logic              cap_wr;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] held_rdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              unused_addr;

  // Byte-lane bit and bits above the word index only alias
  assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+1], req_addr[0]};

  assign req_ready  = (state != WAIT);
  assign busy       = ~req_ready;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == RESP);
  assign resp_wr    = resp_valid & (cap_wr == RESP_WR);
  assign mem_we     = resp_valid & (cap_wr == RESP_WR);

  // Read data is live during the response cycle, otherwise the last read is held
  assign resp_rdata = (resp_valid && cap_wr == RESP_RD) ? mem_rdata : held_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACCEPT_STATE;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          state_next = ACCEPT_STATE;
          cnt_next   = CNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wr    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_wr    <= req_wr;
      cap_idx   <= req_addr[IDX_W:1];
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_rdata <= '0;
    end else if (resp_valid && cap_wr == RESP_RD) begin
      held_rdata <= mem_rdata;
    end
  end

  // Write commits at the edge that ends RESP, so a read accepted there sees it
  mem_array_1rw #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_multicycle_resp.sv
// tb/tb_mem_multicycle_resp.sv - scoreboard bench for mem_multicycle_resp at LATENCY 4 and LATENCY 1
module tb_mem_multicycle_resp;

  typedef struct {
    bit          wr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr [2];
  logic [15:0] req_addr [2];
  logic [15:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_wr [2];
  logic [15:0] resp_rdata [2];
  logic        busy [2];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e;
  logic [15:0] mm [2][1024];
  logic [15:0] last_rd [2];

  mem_multicycle_resp #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_wr(resp_wr[0]), .resp_rdata(resp_rdata[0]),
    .busy(busy[0])
  );

  mem_multicycle_resp #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_wr(resp_wr[1]), .resp_rdata(resp_rdata[1]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Request is accepted at the posedge this task returns on
  task automatic issue(input int d, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input bit track);
    int   idx;
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = data;
    n = 0;
    while (!req_ready[d] && n < 64) begin
      chk("busy_while_waiting", {31'd0, busy[d]}, 32'd1);
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout inst=%0d actual=req_ready 0 required=req_ready 1", d);
      req_valid[d] = 1'b0;
      return;
    end
    idx    = (int'(addr) >> 1) % 1024;
    e.wr   = wr;
    e.data = wr ? 16'h0000 : mm[d][idx];
    e.cyc  = cyc + lat(d);
    if (track) begin
      if (wr) mm[d][idx] = data;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int d, input int n);
    @(negedge clk);
    req_valid[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy_vs_ready", {31'd0, busy[d]}, {31'd0, !req_ready[d]});
        if (resp_valid[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp inst=%0d actual=resp_valid 1 required=no response", d);
          end else begin
            if (d == 0) mon_e = q0.pop_front();
            else mon_e = q1.pop_front();
            chk("resp_cycle", cyc, mon_e.cyc);
            chk("resp_wr", {31'd0, resp_wr[d]}, {31'd0, mon_e.wr});
            if (mon_e.wr) begin
              chk("resp_rdata_hold", {16'd0, resp_rdata[d]}, {16'd0, last_rd[d]});
            end else begin
              chk("resp_rdata", {16'd0, resp_rdata[d]}, {16'd0, mon_e.data});
              last_rd[d] = mon_e.data;
            end
          end
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    chk("drain", q0.size() + q1.size(), 0);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid[d]}, 32'd0);
      chk("rst_resp_wr", {31'd0, resp_wr[d]}, 32'd0);
      chk("rst_resp_rdata", {16'd0, resp_rdata[d]}, 32'd0);
    end
  endtask

  task automatic random_run(input int d, input int n);
    logic [15:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = 16'(($urandom % 32) << 11) | 16'(($urandom % 64) << 1) | 16'($urandom % 2);
      issue(d, 1'($urandom % 2), addr, 16'($urandom), 1'b1);
      if ($urandom % 4 == 0) idle(d, int'($urandom % 3));
    end
    idle(d, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      last_rd[d]   = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for word indices 0..63; 0x0030 is zero
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        issue(d, 1'b1, 16'(i * 2), (i == 24) ? 16'h0000 : 16'($urandom), 1'b1);
      end
      idle(d, 0);
    end
    drain();

    // Write then read with the read held until ready
    issue(0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    issue(0, 1'b0, 16'h0010, 16'h0000, 1'b1);
    idle(0, 0);
    drain();

    // Bit-0 and wrap aliasing
    issue(0, 1'b1, 16'h0020, 16'h1234, 1'b1);
    issue(0, 1'b0, 16'h0021, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0820, 16'h0000, 1'b1);
    idle(0, 0);
    drain();

    // Reset mid-operation drops the write and its response
    issue(0, 1'b1, 16'h0030, 16'h5555, 1'b0);
    idle(0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 1'b0, 16'h0030, 16'h0000, 1'b1);
    idle(0, 0);
    drain();

    // Single-cycle latency: alternating write/read every cycle
    for (int i = 0; i < 16; i++) begin
      issue(1, (i % 2) == 0, 16'h0040, 16'(i / 2 + 1), 1'b1);
    end
    idle(1, 0);
    drain();

    random_run(0, 150);
    random_run(1, 150);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
